// File: rtl/pipe_ctrl.sv
// Pipeline control unit: arbitrates execute/trap redirects into one PC redirect,
// and builds per-register stall/flush vectors plus a saturating stall-cycle counter.
module pipe_ctrl #(
    parameter int WIDTH        = 32,
    parameter int STAGES       = 4,
    parameter int HOLD_SRC     = 3,
    parameter int FLUSH_STAGES = 2,
    parameter int FLUSH_CYC    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                jump_en_i,
    input  logic [WIDTH-1:0]    jump_addr_i,
    input  logic                int_jump_en_i,
    input  logic [WIDTH-1:0]    int_jump_addr_i,
    input  logic                pc_ready_i,
    input  logic [HOLD_SRC-1:0] hold_req_i,
    output logic                jump_en_o,
    output logic [WIDTH-1:0]    jump_addr_o,
    output logic [STAGES-1:0]   stall_o,
    output logic [STAGES-1:0]   flush_o,
    output logic                hold_flag_o,
    output logic [31:0]         stall_cnt_o
);

    localparam int FCNT_W = $clog2(FLUSH_CYC + 1);
    localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLUSH_CYC);

    typedef enum logic [1:0] {
        PEND_NONE,
        PEND_EX,
        PEND_INT
    } pend_state_t;

    pend_state_t         pend_state;
    pend_state_t         pend_next;
    logic [WIDTH-1:0]    pend_addr;
    logic [WIDTH-1:0]    pend_addr_next;

    logic                sel_valid;
    logic                sel_int;
    logic [WIDTH-1:0]    sel_addr;
    logic                accept;

    logic [FCNT_W-1:0]   fcnt;
    logic                redirect_flush;

    int                  hold_top;
    logic [STAGES-1:0]   hold_stall;
    logic [STAGES-1:0]   flush_raw;
    logic [31:0]         stall_cnt_q;

    // Priority mux: trap first, then the held redirect, then a fresh execute request.
    always_comb begin
        sel_valid = 1'b0;
        sel_int   = 1'b0;
        sel_addr  = jump_addr_i;
        if (int_jump_en_i) begin
            sel_valid = 1'b1;
            sel_int   = 1'b1;
            sel_addr  = int_jump_addr_i;
        end else if (pend_state != PEND_NONE) begin
            sel_valid = 1'b1;
            sel_int   = (pend_state == PEND_INT);
            sel_addr  = pend_addr;
        end else if (jump_en_i) begin
            sel_valid = 1'b1;
        end
    end

    assign accept = sel_valid & pc_ready_i;

    // An unaccepted selection is held; acceptance drops any concurrent execute request.
    always_comb begin
        pend_next      = pend_state;
        pend_addr_next = pend_addr;
        if (accept) begin
            pend_next = PEND_NONE;
        end else if (sel_valid) begin
            pend_next      = sel_int ? PEND_INT : PEND_EX;
            pend_addr_next = sel_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_state <= PEND_NONE;
            pend_addr  <= '0;
        end else begin
            pend_state <= pend_next;
            pend_addr  <= pend_addr_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt <= '0;
        end else if (accept) begin
            fcnt <= FCNT_LOAD;
        end else if (fcnt != '0) begin
            fcnt <= fcnt - FCNT_W'(1);
        end
    end

    assign redirect_flush = sel_valid | (fcnt != '0);

    // Only the most downstream hold request matters: it stalls everything upstream of it
    // and injects a bubble into the register just after it.
    always_comb begin
        hold_top   = -1;
        hold_stall = '0;
        flush_raw  = '0;
        for (int k = 0; k < HOLD_SRC; k++) begin
            if (hold_req_i[k]) begin
                hold_top = k;
            end
        end
        for (int j = 0; j < STAGES; j++) begin
            hold_stall[j] = (hold_top >= 0) && (j <= hold_top);
            flush_raw[j]  = ((hold_top >= 0) && (j == hold_top + 1))
                          || ((j < FLUSH_STAGES) && redirect_flush);
        end
    end

    assign jump_en_o   = sel_valid & ~rst;
    assign jump_addr_o = rst ? '0 : sel_addr;
    assign flush_o     = rst ? '0 : flush_raw;
    assign stall_o     = rst ? '0 : (hold_stall & ~flush_raw);
    assign hold_flag_o = (|stall_o) | (|flush_o);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall_o[0] && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule
